// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the encryption core and its helpers.
// Contents:
//   - block type: 128 bits, byte 0 at [127:120], column-major state
//   - encryption FSM state enum
//   - round-constant table, indexed directly by the 4-bit round counter
//   - xtime (multiply by x in GF(2^8)) and ShiftRows
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } aes_fsm_e;

  // Entry 0 and 11..15 are never used; padding lets a 4-bit round index it directly.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r of the state rotates left by r columns: out[r+4c] = in[r+4((c+r)%4)].
  function automatic aes_block_t shift_rows(input aes_block_t s);
    return {s[127:120], s[87:80],   s[47:40],   s[7:0],
            s[95:88],   s[55:48],   s[15:8],    s[103:96],
            s[63:56],   s[23:16],   s[111:104], s[71:64],
            s[31:24],   s[119:112], s[79:72],   s[39:32]};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: derives the next round key from the current one.
// Ports:
//   key_in  : current round key (word 0 at [127:96])
//   rcon    : round constant for the key being produced
//   key_out : next round key
module aes_key_step (
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon,
  output logic [127:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w, tmp_w;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_in;
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes_sbox u_sbox (
      .a (rot_w[31 - 8*b -: 8]),
      .y (sub_w[31 - 8*b -: 8])
    );
  end

  assign tmp_w   = sub_w ^ {rcon, 24'h000000};
  assign n0      = w0 ^ tmp_w;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_mix_columns.sv
// AES MixColumns over the full 128-bit state, purely combinational.
// Ports:
//   in_blk  : state after ShiftRows
//   out_blk : each column multiplied by the fixed {02,03,01,01} circulant
module aes_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] in_blk,
  output logic [127:0] out_blk
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] s0, s1, s2, s3;
    assign s0 = in_blk[127 - 32*c -: 8];
    assign s1 = in_blk[119 - 32*c -: 8];
    assign s2 = in_blk[111 - 32*c -: 8];
    assign s3 = in_blk[103 - 32*c -: 8];
    assign out_blk[127 - 32*c -: 8] = xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3;
    assign out_blk[119 - 32*c -: 8] = s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3;
    assign out_blk[111 - 32*c -: 8] = s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3;
    assign out_blk[103 - 32*c -: 8] = xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3);
  end

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
// Ports:
//   a : input byte
//   y : substituted byte
// Built as GF(2^8) inverse (a^254, with 0 -> 0) followed by the affine map.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = x;
    bb = z;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aes_pkg::xtime(aa);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Square-and-multiply: accumulates x^2 * x^4 * ... * x^128 = x^254.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] inv;

  assign inv = gf_inv(a);
  assign y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes128_enc_core.sv
// Iterative AES-128 encryption core with ready/valid handshakes and optional CBC.
// Parameters:
//   SBOX_LANES : bytes substituted per SUB cycle (1, 2, 4, 8 or 16)
//   CBC_EN     : 0 removes chaining; mode and iv are then ignored
// Ports:
//   CLK, reset            : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     : accept handshake for in_data, in_key, mode
//   iv_load, iv           : load the chain register (IDLE only)
//   out_valid/out_ready   : ciphertext handshake, out_data held until taken
//   busy                  : a block is in flight
// Latency from accept to out_valid is 10 * (16/SBOX_LANES + 1) cycles.
module aes128_enc_core
  import aes_pkg::*;
#(
  parameter int SBOX_LANES = 16,
  parameter int CBC_EN     = 1
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  input  logic         mode,
  input  logic         iv_load,
  input  logic [127:0] iv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
        SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
    $error("aes128_enc_core: SBOX_LANES must be 1, 2, 4, 8 or 16");
  end

  localparam int NSTEP = 16 / SBOX_LANES;

  aes_fsm_e   fsm;
  aes_block_t st_blk;
  aes_block_t key_q;
  aes_block_t chain;
  logic [3:0] round;
  logic [3:0] cnt;
  logic       mode_q;

  logic       cbc_now;
  aes_block_t chain_sel;
  aes_block_t sub_blk;
  aes_block_t shifted;
  aes_block_t mixed;
  aes_block_t rk_next;
  aes_block_t round_out;
  logic [7:0] sb_in  [SBOX_LANES];
  logic [7:0] sb_out [SBOX_LANES];

  assign in_ready = (fsm == IDLE);
  assign busy     = (fsm != IDLE);

  assign cbc_now   = (CBC_EN != 0) && mode;
  // An iv presented together with the accepted block takes effect for that block.
  assign chain_sel = iv_load ? iv : chain;

  // SubBytes lanes: lane l of step cnt works on byte cnt*SBOX_LANES + l.
  for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
    logic [7:0] cand [16];
    for (genvar s = 0; s < 16; s++) begin : g_step
      if (s < NSTEP) begin : g_used
        assign cand[s] = st_blk[127 - 8*(s*SBOX_LANES + l) -: 8];
      end else begin : g_pad
        assign cand[s] = 8'h00;
      end
    end
    assign sb_in[l] = cand[cnt];
    aes_sbox u_sbox (
      .a (sb_in[l]),
      .y (sb_out[l])
    );
  end

  for (genvar b = 0; b < 16; b++) begin : g_wb
    assign sub_blk[127 - 8*b -: 8] = (cnt == 4'(b / SBOX_LANES))
                                     ? sb_out[b % SBOX_LANES]
                                     : st_blk[127 - 8*b -: 8];
  end

  aes_key_step u_key_step (
    .key_in  (key_q),
    .rcon    (RCON[round]),
    .key_out (rk_next)
  );

  assign shifted = shift_rows(st_blk);

  aes_mix_columns u_mix (
    .in_blk  (shifted),
    .out_blk (mixed)
  );

  // The final round has no MixColumns.
  assign round_out = ((round == 4'd10) ? shifted : mixed) ^ rk_next;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      fsm       <= IDLE;
      st_blk    <= '0;
      key_q     <= '0;
      chain     <= '0;
      round     <= 4'd0;
      cnt       <= 4'd0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (iv_load && (CBC_EN != 0)) chain <= iv;
          if (in_valid) begin
            st_blk <= in_data ^ in_key ^ (cbc_now ? chain_sel : '0);
            key_q  <= in_key;
            mode_q <= cbc_now;
            round  <= 4'd1;
            cnt    <= 4'd0;
            fsm    <= SUB;
          end
        end
        SUB: begin
          st_blk <= sub_blk;
          if (cnt == 4'(NSTEP - 1)) begin
            cnt <= 4'd0;
            fsm <= MIX;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        MIX: begin
          st_blk <= round_out;
          key_q  <= rk_next;
          if (round == 4'd10) begin
            out_data  <= round_out;
            out_valid <= 1'b1;
            if (mode_q) chain <= round_out;
            fsm <= DONE;
          end else begin
            round <= round + 4'd1;
            fsm   <= SUB;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_enc_core.sv
// Directed bench for aes128_enc_core: three instances (16, 4 and 1 lanes),
// known-answer vectors, CBC chaining, backpressure, mid-block reset and iv_load rules.
module tb_aes128_enc_core;

  typedef logic [127:0] blk_t;

  localparam blk_t KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam blk_t PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam blk_t CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam blk_t KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam blk_t PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam blk_t CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam blk_t IV_F   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam blk_t P1     = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam blk_t P2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam blk_t C1     = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam blk_t C2     = 128'h5086cb9b507219ee95db113a917678b2;
  localparam blk_t ECB_P1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  logic       CLK = 1'b0;
  logic       reset;
  logic [2:0] in_valid_v;
  logic [2:0] in_ready_v;
  logic [2:0] out_valid_v;
  logic [2:0] busy_v;
  blk_t       out_data_v [3];
  blk_t       in_data, in_key, iv;
  logic       mode, iv_load, out_ready;

  int   n_tests = 0;
  int   n_fail  = 0;
  blk_t exp_q [$];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LN = (g == 0) ? 16 : ((g == 1) ? 4 : 1);
    aes128_enc_core #(.SBOX_LANES(LN), .CBC_EN(1)) dut (
      .CLK       (CLK),
      .reset     (reset),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .in_data   (in_data),
      .in_key    (in_key),
      .mode      (mode),
      .iv_load   (iv_load),
      .iv        (iv),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready),
      .out_data  (out_data_v[g]),
      .busy      (busy_v[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic blk_t rnd_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Presents one block at #1 after an edge; returns #1 after the accepting edge.
  task automatic send(input int k, input blk_t pt, input blk_t key, input logic md,
                      input logic ld, input blk_t ivv, input string tag);
    in_data = pt;
    in_key  = key;
    mode    = md;
    iv_load = ld;
    iv      = ivv;
    check({tag, "_in_ready"}, 128'(in_ready_v[k]), 128'(1));
    in_valid_v[k] = 1'b1;
    @(posedge CLK); #1;
    in_valid_v[k] = 1'b0;
    iv_load = 1'b0;
    in_data = rnd_blk();
    in_key  = rnd_blk();
    iv      = rnd_blk();
    mode    = ~md;
    check({tag, "_busy"}, 128'(busy_v[k]), 128'(1));
  endtask

  // Counts edges from accept until out_valid, then scores the ciphertext.
  task automatic recv(input int k, input int lat, input string tag);
    int   cyc;
    blk_t e;
    cyc = 0;
    while (out_valid_v[k] !== 1'b1 && cyc < 400) begin
      @(posedge CLK); #1;
      cyc++;
    end
    check({tag, "_latency"}, 128'(cyc), 128'(lat));
    check({tag, "_sb_depth"}, 128'(exp_q.size()), 128'(1));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, out_data_v[k], e);
    end
  endtask

  task automatic take(input int k, input string tag);
    out_ready = 1'b1;
    @(posedge CLK); #1;
    check({tag, "_ov_low"}, 128'(out_valid_v[k]), 128'(0));
    check({tag, "_in_ready"}, 128'(in_ready_v[k]), 128'(1));
    check({tag, "_idle"}, 128'(busy_v[k]), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    in_valid_v = '0;
    in_data    = '0;
    in_key     = '0;
    iv         = '0;
    mode       = 1'b0;
    iv_load    = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_out_valid", 128'(out_valid_v[0]), 128'(0));
    check("rst_out_data", out_data_v[0], 128'(0));
    check("rst_busy", 128'(busy_v[0]), 128'(0));
    reset = 1'b1;
    @(posedge CLK); #1;
    check("rst_in_ready16", 128'(in_ready_v[0]), 128'(1));
    check("rst_in_ready1", 128'(in_ready_v[2]), 128'(1));

    // FIPS-197 App. B, 16 lanes
    exp_q.push_back(CT_B);
    send(0, PT_B, KEY_B, 1'b0, 1'b0, '0, "fips_b");
    recv(0, 20, "fips_b");
    take(0, "fips_b");

    // FIPS-197 C.1 at 4 and 1 lanes
    exp_q.push_back(CT_C);
    send(1, PT_C, KEY_C, 1'b0, 1'b0, '0, "c1_l4");
    recv(1, 50, "c1_l4");
    take(1, "c1_l4");
    exp_q.push_back(CT_C);
    send(2, PT_C, KEY_C, 1'b0, 1'b0, '0, "c1_l1");
    recv(2, 170, "c1_l1");
    take(2, "c1_l1");

    // CBC: iv loaded in a separate IDLE cycle, then two chained blocks
    iv      = IV_F;
    iv_load = 1'b1;
    @(posedge CLK); #1;
    iv_load = 1'b0;
    exp_q.push_back(C1);
    send(0, P1, KEY_B, 1'b1, 1'b0, '0, "cbc_p1");
    recv(0, 20, "cbc_p1");
    take(0, "cbc_p1");
    exp_q.push_back(C2);
    send(0, P2, KEY_B, 1'b1, 1'b0, '0, "cbc_p2");
    recv(0, 20, "cbc_p2");
    take(0, "cbc_p2");

    // Backpressure: output held, inputs refused
    out_ready = 1'b0;
    exp_q.push_back(CT_B);
    send(0, PT_B, KEY_B, 1'b0, 1'b0, '0, "bp");
    recv(0, 20, "bp");
    for (int i = 0; i < 7; i++) begin
      in_valid_v[0] = 1'b1;
      in_data = rnd_blk();
      @(posedge CLK); #1;
      check("bp_hold_valid", 128'(out_valid_v[0]), 128'(1));
      check("bp_hold_data", out_data_v[0], CT_B);
      check("bp_in_ready", 128'(in_ready_v[0]), 128'(0));
    end
    in_valid_v[0] = 1'b0;
    take(0, "bp_release");

    // Reset during round 5 of a CBC block
    send(0, P1, KEY_B, 1'b1, 1'b0, '0, "abort");
    repeat (9) @(posedge CLK);
    #1;
    reset = 1'b0;
    #1;
    check("abort_out_valid", 128'(out_valid_v[0]), 128'(0));
    check("abort_busy", 128'(busy_v[0]), 128'(0));
    check("abort_out_data", out_data_v[0], 128'(0));
    @(posedge CLK); #1;
    reset = 1'b1;
    @(posedge CLK); #1;
    exp_q.push_back(ECB_P1);
    send(0, P1, KEY_B, 1'b1, 1'b0, '0, "zero_iv");
    recv(0, 20, "zero_iv");
    take(0, "zero_iv");

    // iv_load together with accept takes the new iv
    exp_q.push_back(C1);
    send(0, P1, KEY_B, 1'b1, 1'b1, IV_F, "iv_same");
    recv(0, 20, "iv_same");
    take(0, "iv_same");

    // iv_load while busy and in DONE is ignored; chain stays C1
    out_ready = 1'b0;
    exp_q.push_back(CT_B);
    send(0, PT_B, KEY_B, 1'b0, 1'b0, '0, "iv_busy");
    iv_load = 1'b1;
    iv      = rnd_blk();
    recv(0, 20, "iv_busy");
    repeat (2) @(posedge CLK);
    #1;
    iv_load = 1'b0;
    take(0, "iv_busy");
    exp_q.push_back(C2);
    send(0, P2, KEY_B, 1'b1, 1'b0, '0, "iv_kept");
    recv(0, 20, "iv_kept");
    take(0, "iv_kept");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
